axi_mgr_tx_sequencer: RTL

//  Sequences the AXI manager's five channel enables (tx_en[4:0]: AW,W,B,AR,R) from a queued command stream.

---
 rtl/axi_mgr_tx_sequencer.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mgr_tx_sequencer.sv
// Command sequencer for the AXI manager: buffers read/write commands in a small FIFO, walks each
// one through its channel enables, and returns exactly one response per command. A watchdog
// aborts any transaction that stalls in a wait state.
module axi_mgr_tx_sequencer #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [4:0]        tx_en,
  output logic [ADDR_W-1:0] mgr_tx_AW,
  output logic [DATA_W-1:0] mgr_tx_W,
  output logic [ADDR_W-1:0] mgr_tx_AR,
  input  logic [4:0]        new_data,
  input  logic [1:0]        mgr_bresp,
  input  logic [1:0]        mgr_rresp,
  input  logic [DATA_W-1:0] mgr_rx_R,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [1:0]        rsp_resp,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EntW = 1 + ADDR_W + DATA_W;
  localparam int unsigned WdW  = $clog2(TIMEOUT_CYC + 2);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWrAwW = 3'd1;
  localparam logic [2:0] StWrB   = 3'd2;
  localparam logic [2:0] StRdAr  = 3'd3;
  localparam logic [2:0] StRdR   = 3'd4;
  localparam logic [2:0] StRsp   = 3'd5;

  logic [EntW-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [2:0]        state_q, state_d;
  logic [4:0]        tx_en_q, tx_en_d;
  logic [ADDR_W-1:0] aw_q, aw_d, ar_q, ar_d;
  logic [DATA_W-1:0] w_q, w_d;
  logic [WdW-1:0]    wd_q, wd_d, wd_inc;
  logic              rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              push, pop, abort, wd_hit;
  logic [1:0]        wr_left;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign cmd_ready = (count_q != CntW'(FIFO_DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign {head_write, head_addr, head_data} = mem_q[rd_ptr_q];

  // A zero timeout parks the counter so it can never hit.
  assign wd_inc = (TIMEOUT_CYC == 0) ? wd_q : wd_q + WdW'(1);
  assign wd_hit = (TIMEOUT_CYC != 0) && (wd_inc == WdW'(TIMEOUT_CYC));

  // FIFO storage; contents are discarded on reset simply by clearing the pointers.
  always_ff @(posedge ACLK) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  // FIFO bookkeeping: push and pop may coincide, pointers wrap naturally at a power-of-2 depth.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
  end

  // Transaction FSM, channel enables, watchdog and response capture.
  always_comb begin
    state_d       = state_q;
    tx_en_d       = tx_en_q;
    aw_d          = aw_q;
    w_d           = w_q;
    ar_d          = ar_q;
    wd_d          = wd_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    pop           = 1'b0;
    abort         = 1'b0;
    wr_left       = 2'b00;
    case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop  = 1'b1;
          wd_d = '0;
          if (head_write) begin
            state_d = StWrAwW;
            tx_en_d = 5'b11000;
            aw_d    = head_addr;
            w_d     = head_data;
          end else begin
            state_d = StRdAr;
            tx_en_d = 5'b00010;
            ar_d    = head_addr;
          end
        end
      end
      StWrAwW: begin
        // AW and W complete independently; only still-pending channels count as progress.
        wr_left = tx_en_q[4:3] & ~new_data[4:3];
        if (wr_left == 2'b00) begin
          state_d = StWrB;
          tx_en_d = 5'b00100;
          wd_d    = '0;
        end else if (wr_left != tx_en_q[4:3]) begin
          tx_en_d[4:3] = wr_left;
          wd_d         = '0;
        end else if (wd_hit) begin
          abort = 1'b1;
        end else begin
          wd_d = wd_inc;
        end
      end
      StWrB: begin
        if (new_data[2]) begin
          state_d       = StRsp;
          tx_en_d       = '0;
          wd_d          = '0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b1;
          rsp_resp_d    = mgr_bresp;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
        end else if (wd_hit) begin
          abort = 1'b1;
        end else begin
          wd_d = wd_inc;
        end
      end
      StRdAr: begin
        if (new_data[1]) begin
          state_d = StRdR;
          tx_en_d = 5'b00001;
          wd_d    = '0;
        end else if (wd_hit) begin
          abort = 1'b1;
        end else begin
          wd_d = wd_inc;
        end
      end
      StRdR: begin
        if (new_data[0]) begin
          state_d       = StRsp;
          tx_en_d       = '0;
          wd_d          = '0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b0;
          rsp_resp_d    = mgr_rresp;
          rsp_rdata_d   = mgr_rx_R;
          rsp_timeout_d = 1'b0;
        end else if (wd_hit) begin
          abort = 1'b1;
        end else begin
          wd_d = wd_inc;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          wd_d        = '0;
        end
      end
      default: begin
        state_d = StIdle;
        tx_en_d = '0;
      end
    endcase
    if (abort) begin
      state_d       = StRsp;
      tx_en_d       = '0;
      wd_d          = '0;
      rsp_valid_d   = 1'b1;
      rsp_write_d   = (state_q == StWrAwW) || (state_q == StWrB);
      rsp_resp_d    = 2'b10;
      rsp_rdata_d   = '0;
      rsp_timeout_d = 1'b1;
    end
  end

  // State registers; reset drops the enables and any pending response immediately.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= StIdle;
      tx_en_q       <= '0;
      aw_q          <= '0;
      w_q           <= '0;
      ar_q          <= '0;
      wd_q          <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_resp_q    <= 2'b00;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      tx_en_q       <= tx_en_d;
      aw_q          <= aw_d;
      w_q           <= w_d;
      ar_q          <= ar_d;
      wd_q          <= wd_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign tx_en       = tx_en_q;
  assign mgr_tx_AW   = aw_q;
  assign mgr_tx_W    = w_q;
  assign mgr_tx_AR   = ar_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != StIdle) || (count_q != '0);

endmodule
